uart_tx_tick: RTL and testbench
===============================

Name: uart_tx_tick

Overview:
- Serial UART transmitter that consumes the one-cycle baud enable produced by the clock-divider stage.
- Accepts bytes over a valid/ready handshake into a small FIFO and shifts them out LSB-first as start/data/stop frames.
- All serial timing is derived solely from baud_tick; the block runs entirely in the single system clock domain (no divided clock).
- Sits between the CPU I/O register write path and the TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bit periods per frame (1 or 2).
- FIFO_DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- baud_tick  input  1  one-cycle pulse per bit period, from divider.
- data  input  DATA_BITS  byte to transmit.
- valid  input  1  data is offered this cycle.
- ready  output  1  FIFO can accept; push occurs when valid && ready.
- tx  output  1  serial line, idle high.
- busy  output  1  high while the state machine is not IDLE or the FIFO is non-empty.
- level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; ports are named clk and reset.
- Reset values:
  - tx=1, state=IDLE, FIFO empty, level=0, ready=1, busy=0.
  - Shift register, bit counter and stop counter are all 0.
- Reset mid-frame aborts the frame immediately: tx returns to 1 asynchronously and FIFO contents are discarded.
- FIFO:
  - ready = (level != FIFO_DEPTH).
  - Push on valid && ready; pop is internal.
  - Push and pop in the same cycle leave level unchanged.
  - No fall-through: a byte pushed in cycle N is poppable at the earliest in cycle N+1.
  - valid while full is ignored (no overwrite); data is sampled only on push.
- State machine (registered; advances only in cycles with baud_tick=1; tx is registered and changes in the cycle after the tick edge):
  - IDLE: at a tick with FIFO non-empty → pop into shift reg, tx<=0, go START. At a tick with FIFO empty → stay, tx=1.
  - START: at a tick → tx<=shift[0], bitcnt<=0, go DATA.
  - DATA: at a tick, if bitcnt==DATA_BITS-1 → tx<=1, stopcnt<=0, go STOP; else shift right, tx<=next bit, bitcnt++.
  - STOP: at a tick, if stopcnt==STOP_BITS-1 → (FIFO non-empty: pop, tx<=0, go START; else go IDLE, tx stays 1); else stopcnt++.
- Frame timing:
  - Every line level lasts exactly one baud_tick interval.
  - Frame length = 1 + DATA_BITS + STOP_BITS ticks.
  - Back-to-back frames have no idle gap.
- Latency: the first start bit appears 1 cycle after the first baud_tick that follows a push (the push cycle's own tick does not count).
- busy drops the cycle after the last stop bit completes with the FIFO empty.
- baud_tick held high continuously is legal: one bit per clock.
- No parity. No handshake on the tx side.

Decomposition:
- Package uart_pkg:
  - State enum {IDLE, START, DATA, STOP}.
  - Constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
  - Width helper for level.
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/level, no fall-through.
  - Reused later by the RX path.
- FSM and shifter stay in uart_tx_tick.

Test Plan:
- Single byte: DATA_BITS=8, STOP_BITS=1, baud_tick every 4 clk; push 0x55 → tx after successive ticks = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop); then idle 1; busy falls after the stop period.
- Back-to-back: push 0xA5, 0x0F in consecutive cycles → 20 contiguous bit periods with no idle gap; the second start bit immediately follows the first stop bit; level goes 0→1→2→1→0.
- FIFO full: FIFO_DEPTH=4, baud_tick held 0, push 6 bytes → ready=0 after the 4th push; bytes 5 and 6 are dropped; level=4; enabling ticks transmits exactly the first 4 bytes in order.
- Two stop bits: STOP_BITS=2, push 0xFF → tx is low for 1 tick, high for 10 ticks, and the next start bit is not before tick 12.
- Reset mid-frame: assert reset during data bit 3 of 0x00 → tx=1 in the same cycle (async); level=0; after release no residual frame is sent; a new push transmits correctly.
- Continuous tick: baud_tick=1 constantly, push 0x81 → bit sequence 0,1,0,0,0,0,0,0,1,1 at one bit per clock; start bit appears 1 cycle after the tick following the push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (also intended for the RX path).
//   uart_state_e : frame state machine encoding
//   IDLE_LEVEL   : line level while nothing is being sent (mark)
//   START_LEVEL  : line level of the start bit (space)
//   level_width  : width of a FIFO occupancy count for a given depth
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Occupancy must be able to represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_tick_if.sv
// Byte-stream handshake into the UART transmitter.
//   data  : byte offered by the producer
//   valid : producer offers data this cycle
//   ready : consumer can accept; a transfer happens when valid && ready
// master = producer (CPU write path), slave = transmitter.
interface uart_tx_tick_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO without fall-through: an entry written in one cycle is
// visible on rdata / counted in level from the next cycle on.
//   clk, reset : clock and asynchronous active-high reset
//   push/wdata : write request and data (ignored while full)
//   pop/rdata  : read request (ignored while empty) and head-of-queue data
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] CNT_ONE   = LW'(1);
  localparam logic [LW-1:0] CNT_ZERO  = LW'(0);
  localparam logic [LW-1:0] CNT_FULL  = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = count_r;

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_tick.sv
// UART transmitter driven by a one-cycle baud enable. Bytes enter a small FIFO
// over a valid/ready handshake and leave LSB-first as start/data/stop frames.
// Everything runs on clk; baud_tick only gates when the frame FSM advances.
//   clk, reset : system clock, asynchronous active-high reset
//   baud_tick  : one-cycle pulse per bit period (may be held high: 1 bit/clk)
//   bus        : slave side of the byte handshake (data/valid/ready)
//   tx         : registered serial line, idle high
//   busy       : FSM not idle or FIFO holding bytes
//   level      : FIFO occupancy
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 baud_tick,
  uart_tx_tick_if.slave                        bus,
  output logic                                 tx,
  output logic                                 busy,
  output logic [level_width(FIFO_DEPTH)-1:0]   level
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_ZERO  = BCW'(0);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  // STOP_BITS is 1 or 2, so a single-bit counter covers it.
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [BCW-1:0]       bitcnt_r, bitcnt_s;
  logic                 stopcnt_r, stopcnt_s;
  logic                 tx_r, tx_s;

  logic                 pop_s;
  logic [DATA_BITS-1:0] fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.valid),
    .wdata (bus.data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  assign bus.ready = !fifo_full_s;
  assign tx        = tx_r;
  assign busy      = (state_r != IDLE) || !fifo_empty_s;

  // Frame state, shifter, counters and line driver; reset forces the line idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      bitcnt_r  <= BIT_ZERO;
      stopcnt_r <= 1'b0;
      tx_r      <= IDLE_LEVEL;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bitcnt_r  <= bitcnt_s;
      stopcnt_r <= stopcnt_s;
      tx_r      <= tx_s;
    end
  end

  // Next-state logic; nothing moves except in a baud_tick cycle, so each line
  // level is held for exactly one tick interval.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bitcnt_s  = bitcnt_r;
    stopcnt_s = stopcnt_r;
    tx_s      = tx_r;
    pop_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (baud_tick) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_s = fifo_rdata_s;
            tx_s    = START_LEVEL;
            state_s = START;
          end else begin
            tx_s = IDLE_LEVEL;
          end
        end else begin
          tx_s = tx_r;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_s     = shift_r[0];
          bitcnt_s = BIT_ZERO;
          state_s  = DATA;
        end else begin
          tx_s = tx_r;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bitcnt_r == LAST_BIT) begin
            tx_s      = IDLE_LEVEL;
            stopcnt_s = 1'b0;
            state_s   = STOP;
          end else begin
            // shift_r[0] is on the line now; bit 1 becomes the next one.
            shift_s  = shift_r >> 1;
            tx_s     = shift_r[1];
            bitcnt_s = bitcnt_r + BIT_ONE;
          end
        end else begin
          tx_s = tx_r;
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (stopcnt_r == LAST_STOP) begin
            // Chain straight into the next frame to avoid an idle gap.
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              shift_s = fifo_rdata_s;
              tx_s    = START_LEVEL;
              state_s = START;
            end else begin
              tx_s    = IDLE_LEVEL;
              state_s = IDLE;
            end
          end else begin
            stopcnt_s = stopcnt_r + 1'b1;
          end
        end else begin
          tx_s = tx_r;
        end
      end

      default: begin
        tx_s    = IDLE_LEVEL;
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed, self-checking bench for uart_tx_tick. Instance A uses 8N1 with a
// 4-entry FIFO; instance B uses two stop bits. Expected line sequences come
// from a small frame model (start 0, data LSB-first, stop 1s).
module tb_uart_tx_tick;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic baud_tick;

  always #5 clk = ~clk;

  uart_tx_tick_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_tick_if #(.DATA_BITS(8)) bus_b ();

  logic       tx_a, busy_a, tx_b, busy_b;
  logic [2:0] level_a, level_b;

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .bus(bus_a),
    .tx(tx_a), .busy(busy_a), .level(level_a)
  );

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .bus(bus_b),
    .tx(tx_b), .busy(busy_b), .level(level_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hold_err;
  int exp_q[$];
  int got_tx[$];
  int got_busy[$];
  int got_level[$];

  typedef struct {
    bit       rst_before;
    bit       tick;
    bit       valid;
    bit [7:0] d;
    bit       e_tx;
    bit       e_rdy;
    bit       e_busy;
    int       e_lvl;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    baud_tick = 1'b0;
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
    step();
    step();
    check("rst tx", tx_a, 1);
    check("rst level", level_a, 0);
    check("rst ready", bus_a.ready, 1);
    check("rst busy", busy_a, 0);
    reset = 1'b0;
    step();
  endtask

  task automatic push_byte(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      bus_a.valid = 1'b1;
      bus_a.data  = d;
    end else begin
      bus_b.valid = 1'b1;
      bus_b.data  = d;
    end
    step();
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
  endtask

  // Issue nticks baud ticks, one every 'period' clocks, recording the line after
  // each tick edge and counting any line change between ticks.
  task automatic tick_run(input int sel, input int nticks, input int period);
    int cur;
    got_tx.delete();
    got_busy.delete();
    got_level.delete();
    hold_err = 0;
    for (int t = 0; t < nticks; t++) begin
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      cur = (sel == 0) ? int'(tx_a) : int'(tx_b);
      got_tx.push_back(cur);
      got_busy.push_back((sel == 0) ? int'(busy_a) : int'(busy_b));
      got_level.push_back((sel == 0) ? int'(level_a) : int'(level_b));
      for (int c = 1; c < period; c++) begin
        step();
        if (((sel == 0) ? int'(tx_a) : int'(tx_b)) != cur) hold_err++;
      end
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input int nstop);
    exp_q.push_back(0);
    for (int i = 0; i < 8; i++) exp_q.push_back(int'(d[i]));
    for (int i = 0; i < nstop; i++) exp_q.push_back(1);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1);
  endtask

  task automatic compare_run(input string name);
    check({name, " len"}, got_tx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_tx.size()) check($sformatf("%s bit%0d", name, i), got_tx[i], exp_q[i]);
    end
    check({name, " hold"}, hold_err, 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    baud_tick = 1'b0;
    bus_a.valid = 1'b0;
    bus_a.data  = 8'h00;
    bus_b.valid = 1'b0;
    bus_b.data  = 8'h00;

    // Continuous tick with 0x81, then FIFO fill with ticks held low.
    //             rst  tick valid data   tx  rdy busy lvl
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 2};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 3};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 4};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 4};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 4};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst_before) do_reset();
      baud_tick   = tbl[i].tick;
      bus_a.valid = tbl[i].valid;
      bus_a.data  = tbl[i].d;
      step();
      check($sformatf("vec%0d tx", i), tx_a, tbl[i].e_tx);
      check($sformatf("vec%0d ready", i), bus_a.ready, tbl[i].e_rdy);
      check($sformatf("vec%0d busy", i), busy_a, tbl[i].e_busy);
      check($sformatf("vec%0d level", i), level_a, tbl[i].e_lvl);
    end
    bus_a.valid = 1'b0;
    baud_tick   = 1'b0;

    // Full FIFO drains only the first four bytes, in order.
    tick_run(0, 42, 2);
    add_frame(8'h11, 1);
    add_frame(8'h22, 1);
    add_frame(8'h33, 1);
    add_frame(8'h44, 1);
    add_idle(2);
    compare_run("full");
    check("full end level", level_a, 0);
    check("full end busy", busy_a, 0);

    // Single byte 0x55, tick every 4 clocks.
    do_reset();
    push_byte(0, 8'h55);
    check("single level", level_a, 1);
    tick_run(0, 12, 4);
    add_frame(8'h55, 1);
    add_idle(2);
    compare_run("single");
    check("single busy at stop", got_busy[9], 1);
    check("single busy after", got_busy[10], 0);

    // Back-to-back frames with no idle gap.
    do_reset();
    push_byte(0, 8'hA5);
    check("b2b level1", level_a, 1);
    push_byte(0, 8'h0F);
    check("b2b level2", level_a, 2);
    tick_run(0, 22, 4);
    add_frame(8'hA5, 1);
    add_frame(8'h0F, 1);
    add_idle(2);
    compare_run("b2b");
    check("b2b level after pop1", got_level[0], 1);
    check("b2b level after pop2", got_level[10], 0);
    check("b2b busy end", got_busy[20], 0);

    // Two stop bits: second start bit no earlier than tick 12.
    do_reset();
    push_byte(1, 8'hFF);
    push_byte(1, 8'h00);
    tick_run(1, 24, 3);
    add_frame(8'hFF, 2);
    add_frame(8'h00, 2);
    add_idle(2);
    compare_run("stop2");
    check("stop2 busy end", got_busy[22], 0);

    // Reset during data bit 3 of 0x00 with another byte queued.
    do_reset();
    push_byte(0, 8'h00);
    push_byte(0, 8'h3C);
    tick_run(0, 5, 4);
    check("midrst tx before", tx_a, 0);
    check("midrst level before", level_a, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst tx async", tx_a, 1);
    check("midrst level", level_a, 0);
    check("midrst busy", busy_a, 0);
    step();
    reset = 1'b0;
    step();
    tick_run(0, 12, 4);
    add_idle(12);
    compare_run("postrst idle");
    check("postrst busy", got_busy[11], 0);
    push_byte(0, 8'hC3);
    tick_run(0, 12, 4);
    add_frame(8'hC3, 1);
    add_idle(2);
    compare_run("postrst frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
